// File: rtl/game_timer_ctrl_pkg.sv
// rtl/game_timer_ctrl_pkg.sv - shared state encoding, widths and play-time limit for the game timer
package game_timer_ctrl_pkg;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUNNING  = 2'd1;
    localparam logic [1:0] PAUSED   = 2'd2;
    localparam logic [1:0] FINISHED = 2'd3;

    localparam int DEF_MIN_W          = 6;
    localparam int DEF_SEC_W          = 6;
    localparam int DEF_TIME_LIMIT_MIN = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_RUNNING  = RUNNING,
        ST_PAUSED   = PAUSED,
        ST_FINISHED = FINISHED
    } state_t;

endpackage

// File: rtl/game_timer_ctrl_best_time.sv
// rtl/game_timer_ctrl_best_time.sv - best winning time storage with strict-less-than update
module best_time_reg
    import game_timer_ctrl_pkg::*;
#(
    parameter int MIN_W = DEF_MIN_W,
    parameter int SEC_W = DEF_SEC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             update,
    input  logic [MIN_W-1:0] final_min,
    input  logic [SEC_W-1:0] final_sec,
    output logic [MIN_W-1:0] best_min,
    output logic [SEC_W-1:0] best_sec,
    output logic             best_valid,
    output logic             new_record
);

    // Seconds never exceed 59, so the concatenated key orders times correctly.
    logic better;
    assign better = !best_valid || ({final_min, final_sec} < {best_min, best_sec});

    always_ff @(posedge clk) begin
        if (rst) begin
            best_min   <= '0;
            best_sec   <= '0;
            best_valid <= 1'b0;
            new_record <= 1'b0;
        end else begin
            new_record <= update && better;
            if (update && better) begin
                best_min   <= final_min;
                best_sec   <= final_sec;
                best_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - maps game events onto stopwatch start/pause/stop and tracks final/best times
module game_timer_ctrl
    import game_timer_ctrl_pkg::*;
#(
    parameter int TIME_LIMIT_MIN = DEF_TIME_LIMIT_MIN,
    parameter int MIN_W          = DEF_MIN_W,
    parameter int SEC_W          = DEF_SEC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_start,
    input  logic             menu_open,
    input  logic             game_won,
    input  logic [MIN_W-1:0] sw_minutes,
    input  logic [SEC_W-1:0] sw_seconds,
    output logic             sw_start,
    output logic             sw_pause,
    output logic             sw_stop,
    output logic [MIN_W-1:0] final_min,
    output logic [SEC_W-1:0] final_sec,
    output logic [MIN_W-1:0] best_min,
    output logic [SEC_W-1:0] best_sec,
    output logic             best_valid,
    output logic             new_record,
    output logic             timeout,
    output logic [1:0]       state
);

    state_t state_q, state_d;
    logic   start_d, stop_d, capture_d, timeout_d, win_d;
    logic   win_q;
    logic   limit_hit;

    assign limit_hit = int'(sw_minutes) >= TIME_LIMIT_MIN;
    assign state     = state_q;

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        capture_d = 1'b0;
        timeout_d = timeout;
        win_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISHED: begin
                if (game_start) begin
                    state_d   = ST_RUNNING;
                    start_d   = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            ST_RUNNING: begin
                if (game_won) begin
                    state_d   = ST_FINISHED;
                    stop_d    = 1'b1;
                    capture_d = 1'b1;
                    win_d     = 1'b1;
                end else if (limit_hit) begin
                    state_d   = ST_FINISHED;
                    stop_d    = 1'b1;
                    capture_d = 1'b1;
                    timeout_d = 1'b1;
                end else if (menu_open) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                // Card input is blocked behind the menu, so game_won is ignored here.
                if (game_start) begin
                    state_d = ST_RUNNING;
                    start_d = 1'b1;
                end else if (!menu_open) begin
                    state_d = ST_RUNNING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sw_start  <= 1'b0;
            sw_stop   <= 1'b0;
            sw_pause  <= 1'b0;
            timeout   <= 1'b0;
            final_min <= '0;
            final_sec <= '0;
            win_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sw_start <= start_d;
            sw_stop  <= stop_d;
            sw_pause <= (state_d == ST_PAUSED);
            timeout  <= timeout_d;
            win_q    <= win_d;
            if (capture_d) begin
                final_min <= sw_minutes;
                final_sec <= sw_seconds;
            end
        end
    end

    // Fed from the registered final time, so best lands one cycle after the stop.
    best_time_reg #(
        .MIN_W (MIN_W),
        .SEC_W (SEC_W)
    ) u_best (
        .clk        (clk),
        .rst        (rst),
        .update     (win_q),
        .final_min  (final_min),
        .final_sec  (final_sec),
        .best_min   (best_min),
        .best_sec   (best_sec),
        .best_valid (best_valid),
        .new_record (new_record)
    );

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb/tb_game_timer_ctrl.sv - randomized bench for game_timer_ctrl against a behavioural model
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst, game_start, menu_open, game_won;
    logic [5:0] sw_minutes, sw_seconds;
    logic       sw_start, sw_pause, sw_stop, best_valid, new_record, timeout;
    logic [5:0] final_min, final_sec, best_min, best_sec;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Model: game phase as a plain number, times held as total seconds.
    int m_phase, m_final_s, m_best_s;
    bit m_start, m_stop, m_pause, m_timeout, m_bvalid, m_rec, m_won_prev;

    always #5 clk = ~clk;

    game_timer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .game_start (game_start),
        .menu_open  (menu_open),
        .game_won   (game_won),
        .sw_minutes (sw_minutes),
        .sw_seconds (sw_seconds),
        .sw_start   (sw_start),
        .sw_pause   (sw_pause),
        .sw_stop    (sw_stop),
        .final_min  (final_min),
        .final_sec  (final_sec),
        .best_min   (best_min),
        .best_sec   (best_sec),
        .best_valid (best_valid),
        .new_record (new_record),
        .timeout    (timeout),
        .state      (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int now_s;
        now_s = int'(sw_minutes) * 60 + int'(sw_seconds);
        if (rst) begin
            m_phase = 0; m_final_s = 0; m_best_s = 0;
            m_start = 0; m_stop = 0; m_pause = 0; m_timeout = 0;
            m_bvalid = 0; m_rec = 0; m_won_prev = 0;
            return;
        end
        m_rec = 0;
        if (m_won_prev && (!m_bvalid || m_final_s < m_best_s)) begin
            m_best_s = m_final_s;
            m_bvalid = 1;
            m_rec    = 1;
        end
        m_won_prev = 0;
        m_start = 0;
        m_stop  = 0;
        if (m_phase == 0 || m_phase == 3) begin
            if (game_start) begin m_phase = 1; m_start = 1; m_timeout = 0; end
        end else if (m_phase == 1) begin
            if (game_won) begin
                m_phase = 3; m_stop = 1; m_final_s = now_s; m_won_prev = 1;
            end else if (sw_minutes >= 10) begin
                m_phase = 3; m_stop = 1; m_final_s = now_s; m_timeout = 1;
            end else if (menu_open) begin
                m_phase = 2;
            end
        end else begin
            if (game_start) begin m_phase = 1; m_start = 1; end
            else if (!menu_open) m_phase = 1;
        end
        m_pause = (m_phase == 2);
    endtask

    task automatic compare_all();
        check("state", int'(state), m_phase);
        check("sw_start", int'(sw_start), int'(m_start));
        check("sw_stop", int'(sw_stop), int'(m_stop));
        check("sw_pause", int'(sw_pause), int'(m_pause));
        check("timeout", int'(timeout), int'(m_timeout));
        check("final_min", int'(final_min), m_final_s / 60);
        check("final_sec", int'(final_sec), m_final_s % 60);
        check("best_min", int'(best_min), m_best_s / 60);
        check("best_sec", int'(best_sec), m_best_s % 60);
        check("best_valid", int'(best_valid), int'(m_bvalid));
        check("new_record", int'(new_record), int'(m_rec));
        check("start_stop_excl", int'(sw_start & sw_stop), 0);
    endtask

    task automatic cycle(input bit r, input bit gs, input bit mo, input bit gw,
                         input int mins, input int secs);
        rst        = r;
        game_start = gs;
        menu_open  = mo;
        game_won   = gw;
        sw_minutes = 6'(mins);
        sw_seconds = 6'(secs);
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit mo;
        int mins;
        rst = 1; game_start = 0; menu_open = 0; game_won = 0;
        sw_minutes = 0; sw_seconds = 0;
        @(negedge clk);

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 30);
        cycle(0, 0, 0, 1, 1, 23);
        cycle(0, 0, 0, 0, 1, 24);
        cycle(0, 0, 0, 0, 1, 24);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 10);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 10);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, (i == 10), 2, 5);
        cycle(0, 0, 0, 0, 2, 5);
        cycle(0, 0, 0, 0, 2, 6);
        cycle(0, 0, 0, 0, 9, 59);
        cycle(0, 0, 0, 0, 10, 0);
        cycle(0, 0, 0, 0, 10, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 3, 3);
        cycle(0, 0, 0, 0, 3, 3);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 5);
        cycle(1, 0, 0, 1, 0, 6);
        cycle(0, 0, 0, 0, 0, 0);

        mo = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) mo = !mo;
            mins = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 12) : $urandom_range(0, 9);
            cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 24) == 0,
                  mo,
                  $urandom_range(0, 19) == 0,
                  mins,
                  $urandom_range(0, 59));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
